// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and dmem_responder.
// The master modport is the initiator side and the slave modport is the responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: fixed-latency loads/stores with byte lanes and address aliasing.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err instead of being aligned.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    // IDLE: ready for a request | WAIT: counting down latency | RESP: response held until resp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_func3;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [2:0]  op_func3;
    logic [1:0]  size;
    logic        sign_ext;
    logic        legal;
    logic        misaligned;
    logic        op_err;
    logic [1:0]  off;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mem_we;
    logic        unused_addr_hi;

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // With LATENCY=1 the memory access happens on the accept edge itself, so it uses the live request.
    always_comb begin
        if (LATENCY == 1) begin
            op_we    = bus.req_we;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
            op_func3 = bus.req_func3;
        end else begin
            op_we    = lat_we;
            op_addr  = lat_addr;
            op_wdata = lat_wdata;
            op_func3 = lat_func3;
        end
    end

    assign enter_resp = !rst && ((LATENCY == 1) ? accept : (state == WAIT && cnt == 4'd0));

    always_comb begin
        legal    = 1'b1;
        sign_ext = 1'b0;
        size     = 2'd0;
        case (op_func3)
            3'b000: begin size = 2'd0; sign_ext = 1'b1; end
            3'b001: begin size = 2'd1; sign_ext = 1'b1; end
            3'b010: size = 2'd2;
            3'b100: begin size = 2'd0; legal = !op_we; end
            3'b101: begin size = 2'd1; legal = !op_we; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (size)
            2'd1:    misaligned = op_addr[0];
            2'd2:    misaligned = |op_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign op_err = !legal || misaligned;
    assign off    = op_addr[1:0];
`else
    assign op_err = !legal;
    always_comb begin
        case (size)
            2'd1:    off = {op_addr[1], 1'b0};
            2'd2:    off = 2'b00;
            default: off = op_addr[1:0];
        endcase
    end
`endif

    assign word_idx       = op_addr[2 +: AW];
    assign unused_addr_hi = ^{op_addr[31:AW+2], misaligned};
    assign rd_word        = mem[word_idx];
    assign lane           = rd_word >> {off, 3'b000};

    always_comb begin
        case (size)
            2'd0:    load_data = sign_ext ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
            2'd1:    load_data = sign_ext ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        case (size)
            2'd0: begin
                be = 4'b0001 << off;
                wd = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                be = 4'b0011 << off;
                wd = {2{op_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = op_wdata;
            end
        endcase
    end

    assign mem_we = enter_resp && op_we && !op_err;

    // Storage is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_func3 <= bus.req_func3;
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= op_err;
                            resp_rdata_q <= (op_we || op_err) ? 32'd0 : load_data;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= op_err;
                        resp_rdata_q <= (op_we || op_err) ? 32'd0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-addressed memory model.
// Honors DMEM_MISALIGN_TRAP_EN the same way as the design build.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  bmem [DEPTH*4];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Byte-addressed reference: size/sign from func3, address wrapped to the storage span.
    task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input bit apply,
                            output logic [31:0] rd, output logic er);
        int size;
        bit sgn;
        bit ok;
        int base;
        logic [31:0] v;
        ok = 1; sgn = 0; size = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: begin size = 1; ok = !we; end
            3'd5: begin size = 2; ok = !we; end
            default: ok = 0;
        endcase
        base = int'(addr % (DEPTH*4));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (base % size != 0) ok = 0;
`endif
        base = base - base % size;
        rd = 32'd0;
        er = !ok;
        if (ok && we && apply) begin
            for (int i = 0; i < size; i++) bmem[base+i] = wdata[8*i +: 8];
        end
        if (ok && !we) begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(bmem[base+i]) << (8*i));
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_func3 = f3;
        bus.req_valid = 1'b1;
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic accept(input bit apply, output int waited);
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        model_op(bus.req_we, bus.req_addr, bus.req_wdata, bus.req_func3, apply, exp_rdata, exp_err);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int hold, input string tag);
        int lat;
        logic [31:0] r0;
        logic e0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 40);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        r0 = bus.resp_rdata;
        e0 = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, bus.resp_rdata, r0);
            chk({tag, "_hold_err"}, 32'(bus.resp_err), 32'(e0));
            chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_post_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(bus.req_ready), 32'd1);
        got_rdata = r0;
        got_err   = e0;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int hold, input string tag);
        int w;
        drive(we, addr, wdata, f3);
        accept(1, w);
        chk({tag, "_acc_wait"}, 32'(w), 32'd0);
        wait_resp(hold, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic we;
        logic [2:0] f3;
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_f3 = '{3'd0, 3'd1, 3'd2};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_func3  = 3'd0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH*4; i++) bmem[i] = 8'd0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // fill memory with known random contents
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i*4), $urandom, 3'd2, 0, "init");

        // store then load
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, 0, "sw10");
        chk("sw10_rdata_zero", got_rdata, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 3'd2, 0, "lw10");
        chk("lw10_val", got_rdata, 32'hDEAD_BEEF);
        chk("lw10_err", 32'(got_err), 32'd0);

        // byte store and sign/zero extension
        txn(1'b1, 32'h10, 32'h0000_0000, 3'd2, 0, "sw10z");
        txn(1'b1, 32'h13, 32'h0000_0080, 3'd0, 0, "sb13");
        txn(1'b0, 32'h13, 32'd0, 3'd0, 0, "lb13");
        chk("lb13_val", got_rdata, 32'hFFFF_FF80);
        txn(1'b0, 32'h13, 32'd0, 3'd4, 0, "lbu13");
        chk("lbu13_val", got_rdata, 32'h0000_0080);
        txn(1'b0, 32'h10, 32'd0, 3'd2, 0, "lw10b");
        chk("lw10b_val", got_rdata, 32'h8000_0000);

        // long hold in RESP with the next request already presented
        drive(1'b0, 32'h10, 32'd0, 3'd2);
        accept(1, w);
        drive(1'b0, 32'h13, 32'd0, 3'd4);
        wait_resp(5, "hold");
        chk("hold_val", got_rdata, 32'h8000_0000);
        accept(1, w);
        chk("held_req_wait", 32'(w), 32'd0);
        wait_resp(0, "held");
        chk("held_val", got_rdata, 32'h0000_0080);

        // misaligned word load and illegal func3
        txn(1'b0, 32'h12, 32'd0, 3'd2, 0, "lw12");
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw12_err", 32'(got_err), 32'd1);
        chk("lw12_val", got_rdata, 32'd0);
`else
        chk("lw12_err", 32'(got_err), 32'd0);
        chk("lw12_val", got_rdata, 32'h8000_0000);
`endif
        txn(1'b0, 32'h10, 32'd0, 3'd3, 0, "f3_011");
        chk("f3_011_err", 32'(got_err), 32'd1);
        chk("f3_011_val", got_rdata, 32'd0);
        txn(1'b1, 32'h10, 32'hFFFF_FFFF, 3'd4, 0, "sbu_illegal");
        chk("sbu_illegal_err", 32'(got_err), 32'd1);
        txn(1'b0, 32'h10, 32'd0, 3'd2, 0, "after_illegal");
        chk("after_illegal_val", got_rdata, 32'h8000_0000);

        // reset during WAIT abandons a store; contents survive reset
        txn(1'b1, 32'h20, 32'hCAFE_F00D, 3'd2, 0, "sw20");
        drive(1'b1, 32'h20, 32'h1234_5678, 3'd2);
        accept(0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_ready", 32'(bus.req_ready), 32'd0);
        chk("rstwait_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstwait_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        txn(1'b0, 32'h20, 32'd0, 3'd2, 0, "lw20");
        chk("lw20_val", got_rdata, 32'hCAFE_F00D);

        // reset during RESP drops the response
        drive(1'b0, 32'h20, 32'd0, 3'd2);
        accept(1, w);
        repeat (LAT) @(negedge clk);
        chk("rstresp_valid_before", 32'(bus.resp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstresp_valid_after", 32'(bus.resp_valid), 32'd0);
        chk("rstresp_rdata_after", bus.resp_rdata, 32'd0);
        chk("rstresp_ready_after", 32'(bus.req_ready), 32'd1);

        // aliasing above the storage span
        txn(1'b1, 32'h1000, 32'hA5A5_A5A5, 3'd2, 0, "sw1000");
        txn(1'b0, 32'h0, 32'd0, 3'd2, 0, "lw0");
        chk("lw0_alias", got_rdata, 32'hA5A5_A5A5);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = st_f3[$urandom_range(0, 2)];
            else f3 = ld_f3[$urandom_range(0, 4)];
            txn(we, $urandom, $urandom, f3, $urandom_range(0, 3), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request accept to resp_valid (legal range 1..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 req_func3  input  3  RV32I load/store width code.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_err  output  1  request was illegal; no memory side effect.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE and not in reset.
REQ-016 A request SHALL be accepted on a clock edge with req_valid=1 and req_ready=1; all req_* inputs SHALL be latched on that edge.
REQ-017 On accept, LATENCY=1 SHALL go directly to RESP; otherwise the FSM SHALL go to WAIT with a down-counter loaded with LATENCY-2, and move to RESP on the edge where the counter is 0.
REQ-018 Memory SHALL be read or written exactly once, on the edge entering RESP; resp_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-019 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1, after which the FSM SHALL enter IDLE (req_ready=1 on the next cycle).
REQ-020 Word index SHALL be req_addr[2 +: log2(DEPTH_WORDS)]; higher address bits SHALL be ignored (aliasing wrap-around).
REQ-021 Loads: func3 000 LB and 001 LH SHALL sign-extend, 100 LBU and 101 LHU SHALL zero-extend, and 010 LW SHALL return the full word, with the lane selected by addr[1:0].
REQ-022 Stores: func3 000 SB, 001 SH and 010 SW SHALL write only the addressed byte lanes from req_wdata[7:0], [15:0] or [31:0]; other lanes SHALL remain unchanged.
REQ-023 Any other func3 for the given direction SHALL produce resp_err=1 and resp_rdata=0, with no write.
REQ-024 A load and a store to the same word in consecutive transactions SHALL observe store-then-load ordering (the load returns the new data).

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, the counter 0, and req_ready, resp_valid, resp_rdata and resp_err all 0.
REQ-026 Reset asserted in WAIT SHALL abandon the transaction; a pending store SHALL NOT be written.
REQ-027 Reset asserted in RESP SHALL drop the response without a handshake.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With macro DMEM_MISALIGN_TRAP_EN defined, LH/LHU/SH at odd addresses and LW/SW at addr[1:0]!=0 SHALL give resp_err=1, resp_rdata=0 and no write, with normal latency.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, the block SHALL force the address to natural alignment (clear addr[0] for half, addr[1:0] for word), and misalignment SHALL NOT cause resp_err.

Verification
REQ-031 LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-032 SB 0x13 data 0x80 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable throughout, req_ready stays 0, and a held req_valid is not accepted until 1 cycle after the response handshake.
REQ-034 LW 0x12: with DMEM_MISALIGN_TRAP_EN -> err 1, rdata 0; without it -> err 0, data of word 0x10. func3=011 -> err 1 in both builds.
REQ-035 SW 0x20 data 0x12345678 accepted, rst pulsed 1 cycle in WAIT -> no resp_valid; a later LW 0x20 returns the prior contents.
REQ-036 DEPTH_WORDS=1024: SW 0x1000 data 0xA5A5A5A5, then LW 0x0 -> 0xA5A5A5A5 (alias).
